// File: rtl/spi_reg_sequencer.sv
// rtl/spi_reg_sequencer.sv - register-access sequencer feeding a byte-level SPI master
module spi_reg_sequencer #(
    parameter int            N       = 8,
    parameter int            LW      = 4,
    parameter int            GAP     = 2,
    parameter int            TIMEOUT = 255,
    parameter logic [N-1:0]  DUMMY   = '0
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          req,
    input  logic          req_rw,
    input  logic [N-2:0]  req_addr,
    input  logic [LW-1:0] req_len,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [N-1:0]  wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [N-1:0]  rd_data,
    output logic          rd_valid,
    input  logic          m_ready,
    output logic          m_send,
    output logic [N-1:0]  m_data,
    input  logic          m_arrived,
    input  logic [N-1:0]  m_dataO
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CMD_ISSUE  = 3'd1;
    localparam logic [2:0] S_CMD_WAIT   = 3'd2;
    localparam logic [2:0] S_GAP_WAIT   = 3'd3;
    localparam logic [2:0] S_DATA_ISSUE = 3'd4;
    localparam logic [2:0] S_DATA_WAIT  = 3'd5;

    logic [2:0]    state;
    logic          rw_q;
    logic [N-2:0]  addr_q;
    logic [LW-1:0] remaining;
    logic [TW-1:0] to_cnt;
    logic [GW-1:0] gap_cnt;
    logic          last_byte;

    // The command byte carries no data, so the burst ends there only for len=0.
    assign last_byte = (state == S_CMD_WAIT) ? (remaining == '0) : (remaining == LW'(1));
    assign wr_ready  = (state == S_DATA_ISSUE) & ~rw_q & m_ready & Reset;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            remaining <= '0;
            to_cnt    <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            m_send    <= 1'b0;
            m_data    <= '0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            m_send   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        rw_q      <= req_rw;
                        addr_q    <= req_addr;
                        remaining <= req_len;
                        busy      <= 1'b1;
                        state     <= S_CMD_ISSUE;
                    end
                end
                S_CMD_ISSUE: begin
                    if (m_ready) begin
                        m_send <= 1'b1;
                        m_data <= {rw_q, addr_q};
                        to_cnt <= TW'(TIMEOUT);
                        state  <= S_CMD_WAIT;
                    end
                end
                S_DATA_ISSUE: begin
                    // A write waits on wr_valid without any timeout.
                    if (m_ready && (rw_q || wr_valid)) begin
                        m_send <= 1'b1;
                        m_data <= rw_q ? DUMMY : wr_data;
                        to_cnt <= TW'(TIMEOUT);
                        state  <= S_DATA_WAIT;
                    end
                end
                S_CMD_WAIT, S_DATA_WAIT: begin
                    if (m_arrived) begin
                        if (state == S_DATA_WAIT) begin
                            remaining <= remaining - LW'(1);
                            if (rw_q) begin
                                rd_data  <= m_dataO;
                                rd_valid <= 1'b1;
                            end
                        end
                        if (last_byte) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (GAP > 0) begin
                            gap_cnt <= GW'(GAP);
                            state   <= S_GAP_WAIT;
                        end else begin
                            state <= S_DATA_ISSUE;
                        end
                    end else if (to_cnt <= TW'(1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt - TW'(1);
                    end
                end
                S_GAP_WAIT: begin
                    if (gap_cnt <= GW'(1)) begin
                        state <= S_DATA_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// tb/tb_spi_reg_sequencer.sv - directed bench for spi_reg_sequencer with a simple master model
module tb_spi_reg_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       req = 1'b0;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [3:0] req_len = '0;
    logic       busy, done, err, wr_ready, rd_valid, m_send;
    logic [7:0] wr_data, rd_data, m_data, m_dataO;
    logic       wr_valid, m_ready, m_arrived;

    spi_reg_sequencer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .m_ready   (m_ready),
        .m_send    (m_send),
        .m_data    (m_data),
        .m_arrived (m_arrived),
        .m_dataO   (m_dataO)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // master model and monitor state
    int         cyc = 0;
    int         cd = 0;
    int         stall = 0;
    int         consumed = 0;
    int         stall_after = 0;
    int         stall_len = 0;
    bit         suppress = 0;
    bit         txn_rw = 0;
    int         n_done = 0;
    int         n_err = 0;
    int         done_cyc = 0;
    int         err_cyc = 0;
    int         rdv_cyc = 0;
    logic [7:0] sent[$];
    logic [7:0] resp[$];
    logic [7:0] wq[$];
    logic [7:0] rdq[$];
    logic [7:0] exp_q[$];
    int         send_cyc[$];
    int         arr_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({tag, "_n"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s%0d", tag, i), got[i], exp[i]);
    endtask

    initial begin
        m_ready = 1'b1; m_arrived = 1'b0; m_dataO = '0; wr_valid = 1'b0; wr_data = '0;
        forever begin
            @(posedge Clock); #1;
            cyc++;
            m_arrived = 1'b0;
            if (!Reset) begin
                cd = 0;
                m_ready = 1'b1;
            end else begin
                if (m_send) begin
                    sent.push_back(m_data);
                    send_cyc.push_back(cyc);
                    if (!txn_rw && sent.size() > 1 && wq.size() > 0) begin
                        void'(wq.pop_front());
                        consumed++;
                        if (consumed == stall_after) stall = stall_len;
                    end
                    m_ready = 1'b0;
                    cd = 3;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        m_ready = 1'b1;
                        if (!suppress) begin
                            m_arrived = 1'b1;
                            m_dataO = (resp.size() > 0) ? resp.pop_front() : 8'h00;
                            arr_cyc.push_back(cyc);
                        end
                    end
                end
            end
            if (done) begin n_done++; done_cyc = cyc; end
            if (err)  begin n_err++;  err_cyc = cyc;  end
            if (rd_valid) begin rdq.push_back(rd_data); rdv_cyc = cyc; end
            wr_valid = (wq.size() > 0) && (stall == 0);
            wr_data  = (wq.size() > 0) ? wq[0] : 8'h00;
            if (stall > 0) stall--;
        end
    end

    task automatic tick();
        @(posedge Clock); #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        check("idle_bound", busy, 0);
    endtask

    task automatic start_txn(input bit rw, input logic [6:0] addr, input logic [3:0] len);
        sent.delete(); send_cyc.delete(); arr_cyc.delete(); rdq.delete();
        consumed = 0;
        txn_rw = rw;
        req = 1'b1; req_rw = rw; req_addr = addr; req_len = len;
        tick();
        req = 1'b0;
    endtask

    int d0, e0;

    initial begin
        tick(); tick();
        #2 Reset = 1'b1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_pulses", {done, err, rd_valid, m_send}, 0);
        check("rst_mdata", m_data, 0);
        check("rst_rdata", rd_data, 0);

        // read 0x15, len 2, with req pulses ignored while busy
        d0 = n_done; e0 = n_err;
        resp = {8'hAA, 8'h3C, 8'hC3};
        start_txn(1'b1, 7'h15, 4'd2);
        check("rd_busy", busy, 1);
        req = 1'b1; req_rw = 1'b0; req_addr = 7'h7F; req_len = 4'hF;
        tick(); tick(); tick();
        req = 1'b0;
        wait_idle(200);
        exp_q = {8'h95, 8'h00, 8'h00};
        check_bytes("rd_sent", sent, exp_q);
        exp_q = {8'h3C, 8'hC3};
        check_bytes("rd_data", rdq, exp_q);
        check("rd_done", n_done - d0, 1);
        check("rd_err", n_err - e0, 0);
        check("rd_gap", send_cyc[1] - arr_cyc[0], 4);
        check("rd_gap2", send_cyc[2] - arr_cyc[1], 4);
        check("rd_last_same", rdv_cyc, done_cyc);
        check("rd_done_lat", done_cyc - arr_cyc[2], 1);
        tick(); tick();
        check("rd_ignored_req", busy, 0);

        // write 0x02, len 3, stream stalls 20 cycles before byte 2
        d0 = n_done;
        wq = {8'h11, 8'h22, 8'h33};
        stall_after = 1; stall_len = 20;
        start_txn(1'b0, 7'h02, 4'd3);
        wait_idle(300);
        exp_q = {8'h02, 8'h11, 8'h22, 8'h33};
        check_bytes("wr_sent", sent, exp_q);
        check("wr_rdv", rdq.size(), 0);
        check("wr_done", n_done - d0, 1);
        check("wr_stall", (send_cyc[2] - send_cyc[1]) >= 20, 1);
        stall_after = 0;

        // len=0 read: command byte only
        d0 = n_done;
        start_txn(1'b1, 7'h40, 4'd0);
        wait_idle(100);
        exp_q = {8'hC0};
        check_bytes("l0_sent", sent, exp_q);
        check("l0_done", n_done - d0, 1);
        check("l0_done_lat", done_cyc - arr_cyc[0], 1);
        check("l0_rdv", rdq.size(), 0);

        // command response never arrives
        d0 = n_done; e0 = n_err;
        suppress = 1;
        start_txn(1'b1, 7'h01, 4'd1);
        wait_idle(400);
        suppress = 0;
        check("to_err", n_err - e0, 1);
        check("to_done", n_done - d0, 0);
        check("to_lat", err_cyc - send_cyc[0], 255);
        check("to_sends", sent.size(), 1);

        // reset held low for one cycle in the middle of a read
        d0 = n_done; e0 = n_err;
        resp = {8'hEE, 8'h01, 8'h02, 8'h03};
        start_txn(1'b1, 7'h10, 4'd3);
        for (int i = 0; i < 100 && rdq.size() == 0; i++) tick();
        check("mid_rdv_seen", rdq.size() > 0, 1);
        #2 Reset = 1'b0;
        #1;
        check("mid_rst_out", {busy, done, err, rd_valid, m_send, m_data, rd_data}, 0);
        check("mid_rst_wrrdy", wr_ready, 0);
        @(posedge Clock); #3 Reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("mid_no_pulse", {n_done - d0, n_err - e0}, 0);
        check("mid_idle", busy, 0);

        d0 = n_done;
        resp = {8'h00, 8'h5A};
        start_txn(1'b1, 7'h33, 4'd1);
        wait_idle(100);
        exp_q = {8'hB3, 8'h00};
        check_bytes("post_sent", sent, exp_q);
        exp_q = {8'h5A};
        check_bytes("post_data", rdq, exp_q);
        check("post_done", n_done - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
